// File: rtl/i2c_slave_regif.sv
// I2C slave register interface: synchronised, glitch-filtered SCL/SDA front end feeding a
// byte-level FSM that yields register write/read strobes. Option macro: I2C_SLAVE_AUTOINC_EN.
module i2c_slave_regif #(
  parameter logic [6:0] DEV_ADDR = 7'h3C,
  parameter int         ADDR_W   = 8,
  parameter int         FILT_LEN = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sda_i,
  output logic              sda_o,
  input  logic              scl,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        data_out,
  output logic              write_en,
  input  logic [7:0]        data_in,
  output logic              rd_en,
  output logic              busy
);
  localparam int         PTR_BYTES = (ADDR_W <= 8) ? 1 : 2;
  localparam int         PW        = 8 * PTR_BYTES;
  localparam logic [2:0] FILT_MAX  = 3'(FILT_LEN - 1);
  localparam logic [1:0] PTR_LAST  = 2'(PTR_BYTES);

  typedef enum logic [3:0] {
    IDLE, DEV, ACK_DEV, PTR, ACK_PTR, WR, ACK_WR, RD, RD_ACK
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic              scl_f_q, scl_f_d, sda_f_q, sda_f_d, scl_prev_q, sda_prev_q;
  logic [2:0]        scl_cnt_q, scl_cnt_d, sda_cnt_q, sda_cnt_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic [PW-1:0]     ptr_acc_q, ptr_acc_d;
  logic [1:0]        ptr_cnt_q, ptr_cnt_d;
  logic              rw_q, rw_d, mack_q, mack_d, rd_cap_q, rd_cap_d;
  logic              sda_o_q, sda_o_d, busy_q, busy_d;
  logic              write_en_q, write_en_d, rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
  logic [7:0]        data_out_q, data_out_d;
  logic              scl_rise, scl_fall, start_det, stop_det;

  assign scl_rise  = scl_f_q & ~scl_prev_q;
  assign scl_fall  = ~scl_f_q & scl_prev_q;
  assign start_det = scl_f_q & scl_prev_q & sda_prev_q & ~sda_f_q;
  assign stop_det  = scl_f_q & scl_prev_q & ~sda_prev_q & sda_f_q;

  always_comb begin
    // NOTE: every _d gets a default before any branch, so no path leaves it unassigned (no latch).
    scl_sync_d = {scl_sync_q[0], scl};
    sda_sync_d = {sda_sync_q[0], sda_i};
    // A filtered line flips only after FILT_LEN consecutive samples disagree with it.
    scl_f_d   = scl_f_q;
    scl_cnt_d = '0;
    if (scl_sync_q[1] != scl_f_q) begin
      if (scl_cnt_q == FILT_MAX) scl_f_d = scl_sync_q[1];
      else                       scl_cnt_d = scl_cnt_q + 3'd1;
    end
    sda_f_d   = sda_f_q;
    sda_cnt_d = '0;
    if (sda_sync_q[1] != sda_f_q) begin
      if (sda_cnt_q == FILT_MAX) sda_f_d = sda_sync_q[1];
      else                       sda_cnt_d = sda_cnt_q + 3'd1;
    end

    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    ptr_acc_d  = ptr_acc_q;
    ptr_cnt_d  = ptr_cnt_q;
    rw_d       = rw_q;
    mack_d     = mack_q;
    rd_cap_d   = rd_en_q;
    sda_o_d    = sda_o_q;
    busy_d     = busy_q;
    reg_addr_d = reg_addr_q;
    data_out_d = data_out_q;
    write_en_d = 1'b0;
    rd_en_d    = 1'b0;
`ifdef I2C_SLAVE_AUTOINC_EN
    if (write_en_q) reg_addr_d = reg_addr_q + ADDR_W'(1);
`endif

    if (start_det) begin
      state_d   = DEV;
      bit_cnt_d = '0;
      sda_o_d   = 1'b1;
      rd_cap_d  = 1'b0;
    end else if (stop_det) begin
      state_d  = IDLE;
      sda_o_d  = 1'b1;
      busy_d   = 1'b0;
      rd_cap_d = 1'b0;
    end else begin
      // Read data arrives the cycle after rd_en; its MSB goes out while SCL is still low.
      if (rd_cap_q) begin
        shift_d = data_in;
        sda_o_d = data_in[7];
      end
      case (state_q)
        DEV, PTR, WR: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_f_q};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (state_q == WR && bit_cnt_q == 4'd7) begin
              data_out_d = {shift_q[6:0], sda_f_q};
              write_en_d = 1'b1;
            end
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            bit_cnt_d = '0;
            if (state_q == DEV) begin
              if (shift_q[7:1] == DEV_ADDR) begin
                state_d = ACK_DEV;
                sda_o_d = 1'b0;
                busy_d  = 1'b1;
                rw_d    = shift_q[0];
              end else begin
                state_d = IDLE;
              end
            end else if (state_q == PTR) begin
              state_d   = ACK_PTR;
              sda_o_d   = 1'b0;
              ptr_acc_d = PW'({ptr_acc_q, shift_q});
              ptr_cnt_d = ptr_cnt_q + 2'd1;
            end else begin
              state_d = ACK_WR;
              sda_o_d = 1'b0;
            end
          end
        end
        ACK_DEV, ACK_PTR, ACK_WR: begin
          // The ACK is held low for the whole ninth clock and released on its falling edge.
          if (scl_fall) begin
            sda_o_d   = 1'b1;
            bit_cnt_d = '0;
            if (state_q == ACK_DEV) begin
              ptr_cnt_d = '0;
              if (rw_q) begin
                state_d = RD;
                rd_en_d = 1'b1;
              end else begin
                state_d = PTR;
              end
            end else if (state_q == ACK_PTR && ptr_cnt_q != PTR_LAST) begin
              state_d = PTR;
            end else begin
              if (state_q == ACK_PTR) reg_addr_d = ADDR_W'(ptr_acc_q);
              state_d = WR;
            end
          end
        end
        RD: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              state_d   = RD_ACK;
              sda_o_d   = 1'b1;
              bit_cnt_d = '0;
            end else begin
              shift_d = {shift_q[6:0], 1'b0};
              sda_o_d = shift_q[6];
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            mack_d = sda_f_q;
          end else if (scl_fall) begin
            if (!mack_q) begin
              state_d   = RD;
              rd_en_d   = 1'b1;
              bit_cnt_d = '0;
`ifdef I2C_SLAVE_AUTOINC_EN
              reg_addr_d = reg_addr_q + ADDR_W'(1);
`endif
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_f_q    <= 1'b1;
      sda_f_q    <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      scl_cnt_q  <= '0;
      sda_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      ptr_acc_q  <= '0;
      ptr_cnt_q  <= '0;
      rw_q       <= 1'b0;
      mack_q     <= 1'b1;
      rd_cap_q   <= 1'b0;
      sda_o_q    <= 1'b1;
      busy_q     <= 1'b0;
      reg_addr_q <= '0;
      data_out_q <= '0;
      write_en_q <= 1'b0;
      rd_en_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_f_q    <= scl_f_d;
      sda_f_q    <= sda_f_d;
      scl_prev_q <= scl_f_q;
      sda_prev_q <= sda_f_q;
      scl_cnt_q  <= scl_cnt_d;
      sda_cnt_q  <= sda_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      ptr_acc_q  <= ptr_acc_d;
      ptr_cnt_q  <= ptr_cnt_d;
      rw_q       <= rw_d;
      mack_q     <= mack_d;
      rd_cap_q   <= rd_cap_d;
      sda_o_q    <= sda_o_d;
      busy_q     <= busy_d;
      reg_addr_q <= reg_addr_d;
      data_out_q <= data_out_d;
      write_en_q <= write_en_d;
      rd_en_q    <= rd_en_d;
    end
  end

  assign sda_o    = sda_o_q;
  assign reg_addr = reg_addr_q;
  assign data_out = data_out_q;
  assign write_en = write_en_q;
  assign rd_en    = rd_en_q;
  assign busy     = busy_q;
endmodule

// File: tb/tb_i2c_slave_regif.sv
// Directed bench for i2c_slave_regif: a bus master drives frames on a wired-AND SDA line and a
// transaction-level model (expected write/read queues) is checked by a per-cycle strobe monitor.
`timescale 1ns/1ps
module tb_i2c_slave_regif;
  localparam int HP = 20;
  localparam int Q  = HP / 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1, sda_m = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       sda_o, write_en, rd_en, busy, sda_bus;
  logic [7:0] reg_addr, data_out;

  assign sda_bus = sda_m & sda_o;

  i2c_slave_regif #(.DEV_ADDR(7'h3C), .ADDR_W(8), .FILT_LEN(3)) dut (
    .clk(clk), .rst(rst), .sda_i(sda_bus), .sda_o(sda_o), .scl(scl_m),
    .reg_addr(reg_addr), .data_out(data_out), .write_en(write_en),
    .data_in(data_in), .rd_en(rd_en), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] addr; logic [7:0] data; } wr_t;
  wr_t        exp_wr[$];
  logic [7:0] exp_rd[$];
  int         total = 0, bad = 0;
  int         wr_seen = 0, rd_seen = 0, sda_low_cnt = 0, busy_hi_cnt = 0;
  logic       watch = 1'b0;
  logic [7:0] last_wr_addr = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Register contents served on reads, and where the k-th byte of a burst from base must land.
  function automatic logic [7:0] mem_f(input logic [7:0] a);
    return 8'(a * 7 + 3);
  endfunction
  function automatic logic [7:0] nxt(input logic [7:0] base, input int k);
`ifdef I2C_SLAVE_AUTOINC_EN
    return base + 8'(k);
`else
    return base + 8'(0 * k);
`endif
  endfunction

  always @(negedge clk) begin : mon
    wr_t        e;
    logic [7:0] ea;
    if (!rst) begin
      if (watch) begin
        if (!sda_o) sda_low_cnt++;
        if (busy)   busy_hi_cnt++;
      end
      if (write_en || rd_en) check("strobe_exclusive", write_en & rd_en, 1'b0);
      if (write_en) begin
        wr_seen++;
        last_wr_addr = reg_addr;
        if (exp_wr.size() == 0) check("unexpected_write", write_en, 1'b0);
        else begin
          e = exp_wr.pop_front();
          check("wr_addr", reg_addr, e.addr);
          check("wr_data", data_out, e.data);
        end
      end
      if (rd_en) begin
        rd_seen++;
        if (exp_rd.size() == 0) check("unexpected_read", rd_en, 1'b0);
        else begin
          ea = exp_rd.pop_front();
          check("rd_addr", reg_addr, ea);
        end
      end
    end
  end

  task automatic w(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input logic gl);
    w(Q); sda_m = b; w(Q); scl_m = 1'b1; w(HP / 2);
    if (gl) begin
      sda_m = ~b; w(1); sda_m = b; w(HP / 2 - 1);
    end else begin
      w(HP / 2);
    end
    scl_m = 1'b0;
  endtask

  task automatic recv_bit(output logic b);
    w(Q); sda_m = 1'b1; w(Q); scl_m = 1'b1; w(HP / 2);
    b = sda_bus;
    w(HP / 2); scl_m = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic gl, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i], gl);
    recv_bit(ack);
  endtask

  task automatic recv8(output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
  endtask

  task automatic start_c;
    if (!scl_m) begin
      w(Q); sda_m = 1'b1; w(Q); scl_m = 1'b1;
    end
    w(Q); sda_m = 1'b0; w(HP); scl_m = 1'b0;
  endtask

  task automatic stop_c;
    w(Q); sda_m = 1'b0; w(Q); scl_m = 1'b1; w(HP); sda_m = 1'b1; w(2 * HP);
  endtask

  initial begin
    logic       ack;
    logic [7:0] rb0, rb1;
    logic [7:0] bdat [3];
    bdat[0] = 8'h11; bdat[1] = 8'h22; bdat[2] = 8'h33;

    w(3);
    check("reset_sda_o", sda_o, 1'b1);
    check("reset_reg_addr", reg_addr, 8'h00);
    check("reset_data_out", data_out, 8'h00);
    check("reset_write_en", write_en, 1'b0);
    check("reset_rd_en", rd_en, 1'b0);
    check("reset_busy", busy, 1'b0);
    rst = 1'b0;
    w(10);

    // Single write
    exp_wr.push_back('{8'h10, 8'hA5});
    start_c;
    send_byte(8'h78, 1'b0, ack); check("sw_ack_dev", ack, 1'b0);
    check("sw_busy_after_match", busy, 1'b1);
    send_byte(8'h10, 1'b0, ack); check("sw_ack_ptr", ack, 1'b0);
    send_byte(8'hA5, 1'b0, ack); check("sw_ack_data", ack, 1'b0);
    stop_c;
    check("sw_busy_after_stop", busy, 1'b0);
    check("sw_write_count", wr_seen, 1);
    check("sw_data_out_literal", data_out, 8'hA5);

    // Burst write across the top of the register space
    for (int k = 0; k < 3; k++) exp_wr.push_back('{nxt(8'hFE, k), bdat[k]});
    start_c;
    send_byte(8'h78, 1'b0, ack); check("bw_ack_dev", ack, 1'b0);
    send_byte(8'hFE, 1'b0, ack); check("bw_ack_ptr", ack, 1'b0);
    for (int k = 0; k < 3; k++) begin
      send_byte(bdat[k], 1'b0, ack);
      check("bw_ack_data", ack, 1'b0);
    end
    stop_c;
    check("bw_write_count", wr_seen, 4);
`ifdef I2C_SLAVE_AUTOINC_EN
    check("bw_last_addr_literal", last_wr_addr, 8'h00);
`else
    check("bw_last_addr_literal", last_wr_addr, 8'hFE);
`endif

    // Combined read: pointer write, repeated START, two bytes (ACK then NACK)
    exp_rd.push_back(nxt(8'h20, 0));
    exp_rd.push_back(nxt(8'h20, 1));
    data_in = mem_f(nxt(8'h20, 0));
    start_c;
    send_byte(8'h78, 1'b0, ack); check("rd_ack_dev_w", ack, 1'b0);
    send_byte(8'h20, 1'b0, ack); check("rd_ack_ptr", ack, 1'b0);
    start_c;
    send_byte(8'h79, 1'b0, ack); check("rd_ack_dev_r", ack, 1'b0);
    recv8(rb0);
    data_in = mem_f(nxt(8'h20, 1));
    send_bit(1'b0, 1'b0);
    recv8(rb1);
    send_bit(1'b1, 1'b0);
    w(HP);
    check("rd_sda_released_after_nack", sda_o, 1'b1);
    stop_c;
    check("rd_byte0", rb0, mem_f(nxt(8'h20, 0)));
    check("rd_byte1", rb1, mem_f(nxt(8'h20, 1)));
    check("rd_byte0_literal", rb0, 8'hE3);
    check("rd_rden_count", rd_seen, 2);
    check("rd_busy_after_stop", busy, 1'b0);

    // Address mismatch: the rest of the frame must be ignored
    sda_low_cnt = 0; busy_hi_cnt = 0; watch = 1'b1;
    start_c;
    send_byte(8'h42, 1'b0, ack); check("mm_nack_dev", ack, 1'b1);
    send_byte(8'h10, 1'b0, ack); check("mm_nack_ptr", ack, 1'b1);
    send_byte(8'hA5, 1'b0, ack);
    stop_c;
    watch = 1'b0;
    check("mm_sda_low_cycles", sda_low_cnt, 0);
    check("mm_busy_cycles", busy_hi_cnt, 0);
    check("mm_write_count", wr_seen, 4);

    // One-clk SDA glitches with SCL high: none may be taken as START or STOP
    sda_low_cnt = 0; busy_hi_cnt = 0; watch = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sda_m = 1'b0; w(1); sda_m = 1'b1; w(HP);
    end
    scl_m = 1'b0;
    send_byte(8'h78, 1'b0, ack); check("gl_idle_no_start", ack, 1'b1);
    stop_c;
    watch = 1'b0;
    check("gl_idle_busy_cycles", busy_hi_cnt, 0);
    check("gl_idle_sda_low_cycles", sda_low_cnt, 0);
    exp_wr.push_back('{8'h30, 8'h3C});
    start_c;
    send_byte(8'h78, 1'b0, ack); check("gl_ack_dev", ack, 1'b0);
    send_byte(8'h30, 1'b1, ack); check("gl_ack_ptr", ack, 1'b0);
    send_byte(8'h3C, 1'b1, ack); check("gl_ack_data", ack, 1'b0);
    stop_c;
    check("gl_write_count", wr_seen, 5);

    // Reset after the 4th data bit, then a clean transaction
    start_c;
    send_byte(8'h78, 1'b0, ack); check("rs_ack_dev", ack, 1'b0);
    send_byte(8'h10, 1'b0, ack); check("rs_ack_ptr", ack, 1'b0);
    send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
    w(Q);
    rst = 1'b1;
    #1;
    check("rs_sda_o", sda_o, 1'b1);
    check("rs_reg_addr", reg_addr, 8'h00);
    check("rs_data_out", data_out, 8'h00);
    check("rs_write_en", write_en, 1'b0);
    check("rs_rd_en", rd_en, 1'b0);
    check("rs_busy", busy, 1'b0);
    scl_m = 1'b1; sda_m = 1'b1;
    w(5);
    rst = 1'b0;
    w(HP);
    check("rs_no_write_during_abort", wr_seen, 5);
    exp_wr.push_back('{8'h10, 8'h5A});
    start_c;
    send_byte(8'h78, 1'b0, ack); check("rs2_ack_dev", ack, 1'b0);
    send_byte(8'h10, 1'b0, ack); check("rs2_ack_ptr", ack, 1'b0);
    send_byte(8'h5A, 1'b0, ack); check("rs2_ack_data", ack, 1'b0);
    stop_c;
    check("rs2_write_count", wr_seen, 6);
    check("rs2_data_out_literal", data_out, 8'h5A);
    check("rs2_busy_after_stop", busy, 1'b0);

    check("pending_writes", exp_wr.size(), 0);
    check("pending_reads", exp_rd.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/i2c_slave_regif.md
I2C_SLAVE_REGIF -- requirements
Module: i2c_slave_regif

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h3C: 7-bit slave address matched after START.
REQ-002 SHALL have parameter ADDR_W, default 8, legal 1..16: register pointer width; pointer bytes per transfer = 1 if ADDR_W<=8, else 2 (MSB first).
REQ-003 SHALL have parameter FILT_LEN, default 3, legal 1..7: glitch-filter length in clk cycles for scl/sda.
REQ-004 SHALL have ports, clock and reset first:
- clk, in, 1: single system clock.
- rst, in, 1: asynchronous, active-high reset.
- sda_i, in, 1: SDA line.
- sda_o, out, 1: open-drain drive; 0 = pull low, 1 = release.
- scl, in, 1: SCL line.
- reg_addr, out, ADDR_W: current register pointer.
- data_out, out, 8: last written byte.
- write_en, out, 1: one-clk write strobe.
- data_in, in, 8: read byte, sampled on the cycle after rd_en.
- rd_en, out, 1: one-clk read-fetch strobe.
- busy, out, 1: high from address match until STOP.

Function
REQ-005 SHALL pass scl/sda through a 2-FF synchroniser, then a filter that updates only after FILT_LEN consecutive equal samples.
REQ-006 SHALL detect START as filtered sda 1->0 with scl high, and STOP as sda 0->1 with scl high; bits SHALL be sampled on filtered scl rising edge; sda_o SHALL change only on scl falling edge.
REQ-007 SHALL implement states IDLE, DEV, ACK_DEV, PTR, ACK_PTR, WR, ACK_WR, RD, RD_ACK.
REQ-008 START in any state, including repeated START, SHALL go to DEV with bit counter cleared; STOP in any state SHALL go to IDLE, release sda_o, and clear busy.
REQ-009 In DEV, after 8 bits: address == DEV_ADDR SHALL go to ACK_DEV and assert busy; mismatch SHALL go to IDLE with sda_o released.
REQ-010 ACK_DEV SHALL drive sda_o=0 for one scl period; then R/W=0 goes to PTR, and R/W=1 goes to RD.
REQ-011 PTR SHALL collect 1 or 2 pointer bytes (REQ-002), ACK each, then load reg_addr (bits above ADDR_W discarded); after the last ACK_PTR it SHALL go to WR.
REQ-012 In WR, on the 8th rising scl edge, data_out SHALL load and write_en SHALL pulse exactly one clk, 1-2 cycles after the filtered edge; ACK_WR SHALL then drive ACK.
REQ-013 Entering RD (scl falling after ACK), rd_en SHALL pulse one clk; data_in SHALL be captured on the next clk into a shift register, and its MSB SHALL be driven before scl's next rising edge.
REQ-014 RD_ACK SHALL release sda and sample the master bit: ACK (0) goes to RD for the next byte; NACK (1) keeps sda released and waits for START/STOP.
REQ-015 Pointer arithmetic SHALL be modulo 2^ADDR_W: 2^ADDR_W-1 wraps to 0.
REQ-016 write_en and rd_en SHALL never both be high; neither SHALL pulse outside a matched transaction.

Reset
REQ-017 rst high SHALL immediately set: state IDLE, sda_o=1, reg_addr=0, data_out=0, write_en=0, rd_en=0, busy=0, and filters to 1.
REQ-018 Reset mid-transfer SHALL abort with no strobe; after release, the block SHALL ignore the bus until the next START.

Configuration
REQ-019 Macro I2C_SLAVE_AUTOINC_EN, when defined:
- reg_addr SHALL increment by 1 after each write_en and each master ACK in RD_ACK.
- When undefined, reg_addr SHALL hold the pointer value for the whole transaction.

Verification
REQ-020 Bench SHALL cover:
- Single write: START, 0x78, 0x10, 0xA5, STOP -> one write_en with reg_addr=0x10 and data_out=0xA5; three ACKs; busy low after STOP.
- Burst write with autoinc: ptr 0xFE, data 0x11/0x22/0x33 -> writes at 0xFE, 0xFF, 0x00 (wrap). Without the macro -> all three writes at 0xFE.
- Combined read: write ptr 0x20, repeated START, 0x79, master ACK then NACK -> two rd_en pulses; bus shows the data_in bytes MSB first; sda released after NACK.
- Address mismatch: 0x42 -> sda_o stays 1 for the whole frame; no strobes; busy stays 0.
- Glitch: 1-clk sda pulses with scl high, FILT_LEN=3 -> no START/STOP detected.
- Reset asserted after the 4th data bit -> all outputs at reset values; no write_en; next full transaction completes normally.
